// File: rtl/icache_rvc_assoc_pkg.sv
// Shared constants, FSM state encoding and RVC length decode for the
// set-associative halfword-addressed instruction cache.
package icache_rvc_assoc_pkg;

    localparam int unsigned HW_W    = 16;
    localparam int unsigned BLK_HW  = 8;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned BLK_W   = HW_W * BLK_HW;
    localparam int unsigned BADDR_W = 28;
    localparam int unsigned PADDR_W = 31;

    typedef enum logic [1:0] {
        StIdle,
        StRefillA,
        StRefillB
    } state_t;

    function automatic logic is_32bit(input logic [HW_W-1:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/icache_rvc_assoc_way_array.sv
// Per-way tag/data/valid storage: one write port, two combinational read
// indices (block A and block B of a possibly straddling fetch).
module icache_rvc_assoc_way_array
    import icache_rvc_assoc_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned SETS  = 8,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = BADDR_W - IDX_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [WAYS-1:0]              we_way,
    input  logic [IDX_W-1:0]             w_idx,
    input  logic [TAG_W-1:0]             w_tag,
    input  logic [BLK_W-1:0]             w_data,
    input  logic [IDX_W-1:0]             idx_a,
    input  logic [IDX_W-1:0]             idx_b,
    output logic [WAYS-1:0]              valid_a,
    output logic [WAYS-1:0]              valid_b,
    output logic [WAYS-1:0][TAG_W-1:0]   tag_a,
    output logic [WAYS-1:0][TAG_W-1:0]   tag_b,
    output logic [WAYS-1:0][BLK_W-1:0]   data_a,
    output logic [WAYS-1:0][HW_W-1:0]    data_b0
);

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [SETS-1:0]  valid_q;
        logic [TAG_W-1:0] tag_q  [SETS];
        logic [BLK_W-1:0] data_q [SETS];

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
            end else if (we && we_way[w]) begin
                valid_q[w_idx] <= 1'b1;
            end
        end

        // Tag and data need no reset; valid gates every use.
        always_ff @(posedge clk) begin
            if (we && we_way[w]) begin
                tag_q[w_idx]  <= w_tag;
                data_q[w_idx] <= w_data;
            end
        end

        assign valid_a[w] = valid_q[idx_a];
        assign valid_b[w] = valid_q[idx_b];
        assign tag_a[w]   = tag_q[idx_a];
        assign tag_b[w]   = tag_q[idx_b];
        assign data_a[w]  = data_q[idx_a];
        assign data_b0[w] = data_q[idx_b][HW_W-1:0];
    end

endmodule

// File: rtl/icache_rvc_assoc.sv
// Set-associative read-only RVC instruction cache with LRU replacement,
// straddling 32-bit fetch support and saturating hit/miss counters.
module icache_rvc_assoc
    import icache_rvc_assoc_pkg::*;
#(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned SETS  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 proc_reset,
    input  logic                 proc_read,
    input  logic [PADDR_W-1:0]   proc_addr,
    output logic [31:0]          proc_rdata,
    output logic                 proc_stall,
    output logic                 proc_pcadd,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BADDR_W-1:0]   mem_addr,
    output logic [BLK_W-1:0]     mem_wdata,
    input  logic [BLK_W-1:0]     mem_rdata,
    input  logic                 mem_ready,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = BADDR_W - IDX_W;
    localparam int unsigned AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [WAYS-1:0][AGE_W-1:0] ages_t;

    state_t               state_q;
    logic                 mem_read_q;
    logic [BADDR_W-1:0]   mem_addr_q;
    logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q;
    ages_t                lru_q [SETS];

    logic [BADDR_W-1:0]   blk_a, blk_b;
    logic [OFF_W-1:0]     off, off_p1;
    logic [IDX_W-1:0]     idx_a, idx_b, ref_idx;
    logic [TAG_W-1:0]     tag_a_req, tag_b_req;

    logic [WAYS-1:0]             valid_a, valid_b, valid_ref, we_way;
    logic [WAYS-1:0][TAG_W-1:0]  tag_a, tag_b;
    logic [WAYS-1:0][BLK_W-1:0]  data_a;
    logic [WAYS-1:0][HW_W-1:0]   data_b0;

    logic                 hit_a, hit_b, is32, straddle, access_hit, refill_done;
    int unsigned          way_a, way_b, victim;
    logic [BLK_W-1:0]     line_a;
    logic [HW_W-1:0]      h0, h1, line_b0;
    ages_t                lru_a_nxt, lru_b_base, lru_b_nxt;

    function automatic ages_t lru_touch(input ages_t ages, input int unsigned way);
        ages_t            r;
        logic [AGE_W-1:0] cur;
        r   = ages;
        cur = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w == way) cur = ages[w];
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (w == way)          r[w] = '0;
            else if (ages[w] < cur) r[w] = ages[w] + AGE_W'(1);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign blk_a     = proc_addr[PADDR_W-1:OFF_W];
    assign blk_b     = blk_a + BADDR_W'(1);
    assign off       = proc_addr[OFF_W-1:0];
    assign off_p1    = off + OFF_W'(1);
    assign idx_a     = blk_a[IDX_W-1:0];
    assign idx_b     = blk_b[IDX_W-1:0];
    assign tag_a_req = blk_a[BADDR_W-1:IDX_W];
    assign tag_b_req = blk_b[BADDR_W-1:IDX_W];

    icache_rvc_assoc_way_array #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_ways (
        .clk     (clk),
        .rst     (proc_reset),
        .we      (refill_done),
        .we_way  (we_way),
        .w_idx   (ref_idx),
        .w_tag   (mem_addr_q[BADDR_W-1:IDX_W]),
        .w_data  (mem_rdata),
        .idx_a   (idx_a),
        .idx_b   (idx_b),
        .valid_a (valid_a),
        .valid_b (valid_b),
        .tag_a   (tag_a),
        .tag_b   (tag_b),
        .data_a  (data_a),
        .data_b0 (data_b0)
    );

    always_comb begin
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        way_a   = 0;
        way_b   = 0;
        line_a  = '0;
        line_b0 = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_a[w] && tag_a[w] == tag_a_req) begin
                hit_a  = 1'b1;
                way_a  = w;
                line_a = data_a[w];
            end
            if (valid_b[w] && tag_b[w] == tag_b_req) begin
                hit_b   = 1'b1;
                way_b   = w;
                line_b0 = data_b0[w];
            end
        end
    end

    assign h0         = line_a[{off, 4'b0000} +: HW_W];
    assign is32       = is_32bit(h0);
    assign straddle   = (off == OFF_W'(BLK_HW - 1)) && is32;
    assign h1         = straddle ? line_b0 : line_a[{off_p1, 4'b0000} +: HW_W];
    assign access_hit = (state_q == StIdle) && proc_read && hit_a && (!straddle || hit_b);

    assign proc_stall = (state_q != StIdle) || (proc_read && !access_hit);
    assign proc_pcadd = access_hit && is32;
    assign proc_rdata = !access_hit ? 32'h0 : (is32 ? {h1, h0} : {16'h0, h0});

    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    // Victim: lowest-index invalid way, else the way whose age is oldest.
    assign ref_idx     = mem_addr_q[IDX_W-1:0];
    assign valid_ref   = (state_q == StRefillB) ? valid_b : valid_a;
    assign refill_done = (state_q != StIdle) && mem_ready && !proc_reset;

    always_comb begin
        logic found;
        found  = 1'b0;
        victim = 0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_ref[w] && !found) begin
                victim = w;
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (lru_q[ref_idx][w] == AGE_W'(WAYS - 1)) victim = w;
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            we_way[w] = (w == victim);
        end
    end

    // A then B; when both map to one set the B update builds on the A result.
    always_comb begin
        lru_a_nxt  = lru_touch(lru_q[idx_a], way_a);
        lru_b_base = (idx_b == idx_a) ? lru_a_nxt : lru_q[idx_b];
        lru_b_nxt  = lru_touch(lru_b_base, way_b);
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    lru_q[s][w] <= AGE_W'(w);
                end
            end
        end else if (refill_done) begin
            lru_q[ref_idx] <= lru_touch(lru_q[ref_idx], victim);
        end else if (access_hit) begin
            lru_q[idx_a] <= lru_a_nxt;
            if (straddle) lru_q[idx_b] <= lru_b_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= StIdle;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (proc_read) begin
                        if (!hit_a) begin
                            state_q    <= StRefillA;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= blk_a;
                            miss_cnt_q <= sat_inc(miss_cnt_q);
                        end else if (straddle && !hit_b) begin
                            state_q    <= StRefillB;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= blk_b;
                            miss_cnt_q <= sat_inc(miss_cnt_q);
                        end else begin
                            hit_cnt_q  <= sat_inc(hit_cnt_q);
                        end
                    end
                end
                StRefillA, StRefillB: begin
                    if (mem_ready) begin
                        state_q    <= StIdle;
                        mem_read_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_rvc_assoc.sv
// Randomised bench for icache_rvc_assoc against a recency-list cache model.
module tb_icache_rvc_assoc;

    localparam int unsigned WAYS  = 2;
    localparam int unsigned SETS  = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         proc_reset = 1'b1;
    logic         proc_read = 1'b0;
    logic [30:0]  proc_addr = '0;
    logic [31:0]  proc_rdata;
    logic         proc_stall, proc_pcadd;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    icache_rvc_assoc #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .proc_pcadd (proc_pcadd),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Backing memory: hashed contents, with a few blocks pinned by hand.
    logic [127:0] ovr [logic [27:0]];

    function automatic logic [127:0] mem_blk(input logic [27:0] b);
        logic [127:0] r;
        logic [31:0]  x;
        if (ovr.exists(b)) return ovr[b];
        for (int k = 0; k < 8; k++) begin
            x = 32'(b) * 32'h9E37_79B1 + 32'(k) * 32'h85EB_CA6B;
            x = x ^ (x >> 15);
            r[k*16 +: 16] = x[15:0];
        end
        return r;
    endfunction

    task automatic set_hw(input logic [27:0] b, input int k, input logic [15:0] v);
        logic [127:0] x;
        x = mem_blk(b);
        x[k*16 +: 16] = v;
        ovr[b] = x;
    endtask

    // Model: per set, resident blocks ordered most- to least-recently used.
    logic [27:0] m_blk [SETS][WAYS];
    int          m_n   [SETS];
    int          m_hit, m_miss;

    function automatic int m_find(input logic [27:0] b);
        int s = int'(b % SETS);
        for (int i = 0; i < m_n[s]; i++) if (m_blk[s][i] == b) return i;
        return -1;
    endfunction

    task automatic m_touch(input logic [27:0] b);
        int s = int'(b % SETS);
        int p = m_find(b);
        for (int i = p; i > 0; i--) m_blk[s][i] = m_blk[s][i-1];
        m_blk[s][0] = b;
    endtask

    task automatic m_insert(input logic [27:0] b);
        int s = int'(b % SETS);
        if (m_n[s] < int'(WAYS)) m_n[s]++;
        for (int i = m_n[s] - 1; i > 0; i--) m_blk[s][i] = m_blk[s][i-1];
        m_blk[s][0] = b;
    endtask

    task automatic m_clear();
        for (int s = 0; s < int'(SETS); s++) m_n[s] = 0;
        m_hit  = 0;
        m_miss = 0;
    endtask

    // Per-cycle expectations, set by the driver just after each rising edge.
    logic        exp_on = 1'b0, exp_stall, exp_mread, exp_hitcyc, exp_pcadd, exp_rfirst;
    logic [27:0] exp_maddr;
    logic [31:0] exp_rdata;
    logic [31:0] cap_rdata;
    logic        cap_pcadd;
    logic [27:0] cap_addrs [$];

    task automatic set_exp(input logic stall, input logic mread, input logic [27:0] maddr,
                           input logic hitcyc, input logic [31:0] rdata, input logic pcadd,
                           input logic rfirst);
        exp_on     = 1'b1;
        exp_stall  = stall;
        exp_mread  = mread;
        exp_maddr  = maddr;
        exp_hitcyc = hitcyc;
        exp_rdata  = rdata;
        exp_pcadd  = pcadd;
        exp_rfirst = rfirst;
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("stall", proc_stall, exp_stall);
            chk("mem_read", mem_read, exp_mread);
            if (exp_mread) chk("mem_addr", mem_addr, exp_maddr);
            if (!exp_stall) begin
                chk("rdata", proc_rdata, exp_rdata);
                chk("pcadd", proc_pcadd, exp_pcadd);
            end
            chk("hit_cnt", hit_cnt, m_hit);
            chk("miss_cnt", miss_cnt, m_miss);
            chk("mem_wr_zero", {mem_write, |mem_wdata}, 0);
            if (exp_hitcyc) begin
                cap_rdata = proc_rdata;
                cap_pcadd = proc_pcadd;
            end
            if (exp_rfirst) cap_addrs.push_back(mem_addr);
        end
    end

    task automatic cyc_idle();
        proc_read = 1'b0;
        proc_addr = 31'($urandom);
        set_exp(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        exp_on     = 1'b0;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        m_clear();
        @(negedge clk);
        chk("reset_mem_addr", mem_addr, 28'h0);
        chk("reset_mem_read", mem_read, 0);
        chk("reset_counters", {hit_cnt, miss_cnt}, 0);
        @(posedge clk);
        #1;
    endtask

    // One fetch from request to hit; nref returns how many refills it took.
    task automatic fetch(input logic [30:0] a, output int nref);
        logic [27:0]  ba, bb, blk;
        logic [127:0] la, lb;
        logic [15:0]  h0, h1;
        logic         s32, strad, done;
        int           o, lat;
        ba = a[30:3];
        bb = ba + 28'd1;
        o = int'(a[2:0]);
        nref = 0;
        done = 1'b0;
        proc_read = 1'b1;
        proc_addr = a;
        for (int it = 0; it < 3 && !done; it++) begin
            s32 = 1'b0;
            strad = 1'b0;
            blk = ba;
            la = mem_blk(ba);
            lb = mem_blk(bb);
            if (m_find(ba) >= 0) begin
                h0 = la[o*16 +: 16];
                s32 = (h0[1:0] == 2'b11);
                strad = s32 && (o == 7);
                if (strad && m_find(bb) < 0) blk = bb;
                else done = 1'b1;
            end
            if (done) begin
                h1 = (o == 7) ? lb[15:0] : la[(o+1)*16 +: 16];
                set_exp(1'b0, 1'b0, '0, 1'b1, s32 ? {h1, h0} : {16'h0, h0}, s32, 1'b0);
                @(posedge clk);
                m_touch(ba);
                if (strad) m_touch(bb);
                if (m_hit < CMAX) m_hit++;
                #1;
            end else begin
                set_exp(1'b1, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0);
                @(posedge clk);
                if (m_miss < CMAX) m_miss++;
                #1;
                lat = $urandom_range(0, 3);
                for (int c = 0; c <= lat; c++) begin
                    set_exp(1'b1, 1'b1, blk, 1'b0, 32'h0, 1'b0, c == 0);
                    mem_ready = (c == lat);
                    mem_rdata = (c == lat) ? mem_blk(blk) : {$urandom, $urandom, $urandom, $urandom};
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b0;
                end
                m_insert(blk);
                nref++;
            end
        end
    endtask

    int n;

    initial begin
        set_hw(28'h2, 0, 16'h4501);
        set_hw(28'h2, 2, 16'h0513);
        set_hw(28'h2, 3, 16'h0000);
        set_hw(28'h20, 7, 16'h0093);
        set_hw(28'h21, 0, 16'h0010);
        set_hw(28'hFFF_FFFF, 7, 16'h00B7);
        set_hw(28'h0, 0, 16'hABCD);

        do_reset();
        cyc_idle();

        // Cold compressed fetch
        cap_addrs.delete();
        fetch(31'h0000_0010, n);
        chk("cold_nref", n, 1);
        chk("cold_maddr", cap_addrs[0], 28'h2);
        chk("cold_rdata", cap_rdata, 32'h0000_4501);
        chk("cold_pcadd", cap_pcadd, 0);
        chk("cold_miss_cnt", miss_cnt, 1);

        // Same block, 32-bit, immediate hit
        fetch(31'h0000_0012, n);
        chk("hit_nref", n, 0);
        chk("hit_rdata", cap_rdata, 32'h0000_0513);
        chk("hit_pcadd", cap_pcadd, 1);

        // Straddle needing both blocks
        cap_addrs.delete();
        fetch(31'h0000_0107, n);
        chk("strad_nref", n, 2);
        chk("strad_addr_a", cap_addrs[0], 28'h20);
        chk("strad_addr_b", cap_addrs[1], 28'h21);
        chk("strad_rdata", cap_rdata, 32'h0010_0093);
        chk("strad_pcadd", cap_pcadd, 1);
        chk("strad_miss_cnt", miss_cnt, 3);

        // Straddle across the top of the block address space
        cap_addrs.delete();
        fetch(31'h7FFF_FFFF, n);
        chk("wrap_nref", n, 2);
        chk("wrap_addr_b", cap_addrs[1], 28'h0);
        chk("wrap_rdata", cap_rdata, 32'hABCD_00B7);

        // LRU eviction in set 0
        do_reset();
        fetch({28'd0, 3'd0}, n);  chk("lru_0", n, 1);
        fetch({28'd8, 3'd0}, n);  chk("lru_8", n, 1);
        fetch({28'd0, 3'd0}, n);  chk("lru_0_again", n, 0);
        fetch({28'd16, 3'd0}, n); chk("lru_16", n, 1);
        fetch({28'd0, 3'd0}, n);  chk("lru_0_kept", n, 0);
        fetch({28'd8, 3'd0}, n);  chk("lru_8_evicted", n, 1);

        // Reset in the middle of a refill, then a late mem_ready
        do_reset();
        proc_read = 1'b1;
        proc_addr = {28'h5, 3'd1};
        set_exp(1'b1, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        m_miss = 1;
        #1;
        set_exp(1'b1, 1'b1, 28'h5, 1'b0, 32'h0, 1'b0, 1'b0);
        proc_reset = 1'b1;
        @(posedge clk);
        m_clear();
        #1;
        proc_reset = 1'b0;
        proc_read = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = mem_blk(28'h5);
        set_exp(1'b0, 1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        cyc_idle();
        fetch({28'h5, 3'd1}, n);
        chk("rst_refetch_nref", n, 1);

        // Hit counter saturation
        do_reset();
        fetch(31'h0000_0010, n);
        for (int i = 0; i < 20; i++) fetch(31'h0000_0010, n);
        chk("hit_sat", hit_cnt, 4'hF);

        // Randomised traffic over a small conflicting block range
        do_reset();
        for (int t = 0; t < 700; t++) begin
            logic [27:0] b;
            logic [2:0]  off;
            if ($urandom_range(0, 4) == 0) cyc_idle();
            if ($urandom_range(0, 150) == 0) do_reset();
            b = ($urandom_range(0, 15) == 0) ? 28'hFFF_FFFF - 28'($urandom_range(0, 3))
                                             : 28'($urandom_range(0, 63));
            off = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            fetch({b, off}, n);
        end
        cyc_idle();
        exp_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
